// File: rtl/program_loader.sv
// program_loader
//   Receives a framed byte stream over a valid/ready handshake, writes the
//   payload into the 4096x8 program memory, verifies an 8-bit additive
//   checksum, then loads the program counter with the image start address
//   and releases the CPU from hold.
//
//   Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, N data bytes, CHK
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   in_valid      in_data holds a byte
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle (low only in START)
//   mem_we        program memory write enable (one cycle per data byte)
//   mem_addr      program memory write address
//   mem_wdata     program memory write data
//   pc_load       one-cycle pulse loading the program counter
//   pc_load_data  start address loaded into the program counter
//   cpu_hold      gates the CPU counter enable while high
//   busy          frame in progress (not IDLE, not ERROR)
//   done          last frame loaded successfully
//   error         last frame rejected (sticky until next SYNC)
//
// state  | meaning
// IDLE   | waiting for SYNC, other bytes dropped
// S_AH   | expecting start address high nibble
// S_AL   | expecting start address low byte
// S_LH   | expecting length high nibble
// S_LL   | expecting length low byte, range check
// DATA   | writing payload bytes
// CHECK  | expecting checksum byte
// START  | pc_load pulse, input stalled
// ERROR  | frame rejected, waiting for SYNC

module program_loader #(
    parameter int          ADDR_W = 12,
    parameter int          DATA_W = 8,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] S_AH  = 4'd1;
    localparam logic [3:0] S_AL  = 4'd2;
    localparam logic [3:0] S_LH  = 4'd3;
    localparam logic [3:0] S_LL  = 4'd4;
    localparam logic [3:0] DATA  = 4'd5;
    localparam logic [3:0] CHECK = 4'd6;
    localparam logic [3:0] START = 4'd7;
    localparam logic [3:0] ERROR = 4'd8;

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [3:0]        len_h_q, len_h_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pc_load_q, pc_load_d;
    logic [ADDR_W-1:0] pc_load_data_q, pc_load_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [ADDR_W-1:0] len_n;
    logic [ADDR_W:0]   end_addr;
    logic [DATA_W-1:0] chk_sum;

    assign in_ready = (state_q != START);
    assign accept   = in_valid & in_ready;

    // Length as it would be once the low byte is taken in S_LL; end_addr is
    // one wider so that start + N == 4096 (last byte at 12'hFFF) is legal.
    assign len_n    = {len_h_q, in_data};
    assign end_addr = {1'b0, start_q} + {1'b0, len_n};
    assign chk_sum  = acc_q + in_data;

    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        len_h_d        = len_h_q;
        cnt_d          = cnt_q;
        wr_addr_d      = wr_addr_q;
        acc_d          = acc_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        pc_load_d      = 1'b0;
        pc_load_data_d = pc_load_data_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        error_d        = error_q;

        case (state_q)
            IDLE, ERROR: begin
                if (accept && in_data == SYNC) begin
                    state_d    = S_AH;
                    acc_d      = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_AH: begin
                if (accept) begin
                    if (in_data[7:4] != 4'h0) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        start_d[11:8] = in_data[3:0];
                        state_d       = S_AL;
                    end
                end
            end
            S_AL: begin
                if (accept) begin
                    start_d[7:0] = in_data;
                    state_d      = S_LH;
                end
            end
            S_LH: begin
                if (accept) begin
                    if (in_data[7:4] != 4'h0) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        len_h_d = in_data[3:0];
                        state_d = S_LL;
                    end
                end
            end
            S_LL: begin
                if (accept) begin
                    if (len_n == '0 || end_addr > 13'h1000) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        cnt_d     = len_n;
                        wr_addr_d = start_q;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr_q;
                    mem_wdata_d = in_data;
                    wr_addr_d   = wr_addr_q + 1'b1;
                    acc_d       = chk_sum;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == 12'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (chk_sum == 8'h00) begin
                        state_d        = START;
                        pc_load_d      = 1'b1;
                        pc_load_data_d = start_q;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            START: begin
                state_d    = IDLE;
                cpu_hold_d = 1'b0;
                done_d     = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            start_q        <= '0;
            len_h_q        <= '0;
            cnt_q          <= '0;
            wr_addr_q      <= '0;
            acc_q          <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            pc_load_q      <= 1'b0;
            pc_load_data_q <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            len_h_q        <= len_h_d;
            cnt_q          <= cnt_d;
            wr_addr_q      <= wr_addr_d;
            acc_q          <= acc_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            pc_load_q      <= pc_load_d;
            pc_load_data_q <= pc_load_data_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign pc_load      = pc_load_q;
    assign pc_load_data = pc_load_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign busy         = (state_q != IDLE) && (state_q != ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed frames, with expected memory writes
// and program-counter loads queued as stimulus is driven and compared as the
// DUT produces them.

module tb_program_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        pc_load;
    logic [11:0] pc_load_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] exp_wr[$];
    logic [11:0] exp_pc[$];
    logic [7:0]  fd[$];
    logic [11:0] last_pc = 12'h000;

    program_loader dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .pc_load      (pc_load),
        .pc_load_data (pc_load_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every write / pc load must match the head of its queue.
    always @(negedge clock) begin
        if (mem_we) begin
            check("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                logic [19:0] w;
                w = exp_wr.pop_front();
                check("wr_addr", mem_addr, w[19:8]);
                check("wr_data", mem_wdata, w[7:0]);
            end
        end
        if (pc_load) begin
            check("pc_expected", exp_pc.size() != 0, 1);
            if (exp_pc.size() != 0) begin
                logic [11:0] p;
                p = exp_pc.pop_front();
                check("pc_load_data", pc_load_data, p);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (i > 0) @(negedge clock);
            acc = in_ready;
            @(posedge clock);
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_header(input logic [11:0] st, input logic [11:0] n);
        send_byte(8'hA5);
        send_byte({4'h0, st[11:8]});
        send_byte(st[7:0]);
        send_byte({4'h0, n[11:8]});
        send_byte(n[7:0]);
    endtask

    // Sends a full frame from fd[]; chk_x corrupts the checksum when nonzero.
    task automatic send_frame(input logic [11:0] st, input logic [7:0] chk_x,
                              input bit gap, input bit ok, input string tag);
        logic [7:0]  sum;
        logic [11:0] n;
        sum = 8'h00;
        n   = 12'(fd.size());
        send_header(st, n);
        for (int k = 0; k < fd.size(); k++) begin
            exp_wr.push_back({st + 12'(k), fd[k]});
            send_byte(fd[k]);
            sum = sum + fd[k];
            if (gap) idle(2);
        end
        if (ok) exp_pc.push_back(st);
        send_byte((8'h00 - sum) ^ chk_x);
        idle(2);
        if (ok) last_pc = st;
        check({tag, "_done"},     done,         ok);
        check({tag, "_error"},    error,        !ok);
        check({tag, "_cpu_hold"}, cpu_hold,     !ok);
        check({tag, "_busy"},     busy,         0);
        check({tag, "_pc_data"},  pc_load_data, last_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_hold_in",  cpu_hold, 1);
        check("rst_ready_in", in_ready, 1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_outputs", {mem_we, pc_load, done, error, busy}, 5'b0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_addr", mem_addr, 12'h000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_pc_data", pc_load_data, 12'h000);

        // 1: garbage before SYNC is dropped
        send_byte(8'h00);
        send_byte(8'h3C);
        idle(1);
        check("discard_busy", busy, 0);
        check("discard_hold", cpu_hold, 1);

        // 2: basic load
        fd = '{8'h11, 8'h22, 8'h33};
        send_frame(12'h010, 8'h00, 1'b0, 1'b1, "frame_a");

        // 3: bad checksum, then recovery
        send_frame(12'h010, 8'h01, 1'b0, 1'b0, "bad_chk");
        fd = '{8'h7E};
        send_frame(12'h123, 8'h00, 1'b0, 1'b1, "recover");

        // 4: top-of-memory boundary
        fd = '{8'h5A};
        send_frame(12'hFFF, 8'h00, 1'b0, 1'b1, "top_ok");
        send_header(12'hFFF, 12'd2);
        idle(1);
        check("top_ovf_error", error, 1);
        check("top_ovf_done",  done,  0);
        check("top_ovf_hold",  cpu_hold, 1);
        check("top_ovf_busy",  busy, 0);

        // zero-length and bad address nibble are rejected
        send_header(12'h040, 12'd0);
        idle(1);
        check("zero_len_error", error, 1);
        send_byte(8'hA5);
        send_byte(8'h10);
        idle(1);
        check("addr_nib_error", error, 1);
        check("addr_nib_pc", pc_load_data, last_pc);

        // 5: gaps and SYNC-valued data
        fd = '{8'hA5, 8'h01, 8'hA5};
        send_frame(12'h200, 8'h00, 1'b1, 1'b1, "gap_sync");

        // 6: reset mid-frame
        fd = '{8'h01, 8'h02};
        send_frame(12'h080, 8'h00, 1'b0, 1'b1, "pre_rst");
        send_header(12'h300, 12'd3);
        exp_wr.push_back({12'h300, 8'h44});
        send_byte(8'h44);
        send_byte(8'h55);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_we",    mem_we, 0);
        check("mid_rst_flags", {pc_load, done, error, busy}, 4'b0);
        check("mid_rst_hold",  cpu_hold, 1);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_addr",  mem_addr, 12'h000);
        check("mid_rst_pc",    pc_load_data, 12'h000);
        last_pc = 12'h000;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        fd = '{8'hC3, 8'h3C, 8'h99};
        send_frame(12'h400, 8'h00, 1'b0, 1'b1, "post_rst");

        idle(3);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("pc_queue_empty", exp_pc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
